// File: rtl/ram_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder_pkg
// Purpose  : Shared I/O-window constants and offset decode for the RAM/IO responder.
// Revision : 1.0 - initial release
// ============================================================================
package ram_io_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [2:0]  IO_DATA_OFS = 3'h0;
    localparam logic [2:0]  IO_CTRL_OFS = 3'h4;

    typedef enum logic [1:0] {
        IO_SEL_NONE = 2'd0,
        IO_SEL_DATA = 2'd1,
        IO_SEL_CTRL = 2'd2
    } io_sel_e;

    function automatic io_sel_e io_decode(input logic [2:0] ofs);
        case (ofs)
            IO_DATA_OFS: return IO_SEL_DATA;
            IO_CTRL_OFS: return IO_SEL_CTRL;
            default:     return IO_SEL_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder_if
// Purpose  : Byte-wide memory-controller bus (rw/addr/wdata in, rdata out).
// Revision : 1.0 - initial release
// ============================================================================
interface ram_io_responder_if;

    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport master (
        output ram_rw,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_rw,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );

endinterface
`default_nettype wire

// File: rtl/ram_io_responder_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Purpose  : Small synchronous FIFO; a push into a full FIFO lands when a pop
//            happens in the same cycle, a pop from an empty FIFO is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int W   = 8,
    parameter int LOG = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   din_i,
    output logic           full_o,
    output logic           empty_o,
    output logic [LOG:0]   count_o,
    output logic [W-1:0]   head_o
);

    localparam int DEPTH = 1 << LOG;

    logic [W-1:0]   mem_q [DEPTH];
    logic [LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG:0]   count_q,  count_d;
    logic           w_pop_ok;
    logic           w_push_ok;

    assign full_o   = (count_q == (LOG+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_o   = mem_q[rd_ptr_q];

    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + LOG'(1);
        if (w_pop_ok)  rd_ptr_d = rd_ptr_q + LOG'(1);
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + (LOG+1)'(1);
            2'b01:   count_d = count_q - (LOG+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; emptiness is tracked purely by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder
// Purpose  : RAM-side bus responder: byte RAM plus an I/O window with TX/RX
//            console FIFOs and a sticky halt register.
// Revision : 1.0 - initial release
// ============================================================================
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_AW   = 17,
    parameter int IO_BIT   = 17,
    parameter int FIFO_LOG = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_i,
    ram_io_responder_if.slave     bus,
    output logic                  io_tx_full_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    output logic                  tx_overflow_o,
    output logic                  sim_halt_o
);

    logic [7:0]        mem_q [2**RAM_AW];
    logic [7:0]        rdata_q, rdata_d;
    logic              overflow_q, overflow_d;
    logic              halt_q, halt_d;

    logic [RAM_AW-1:0] w_idx;
    logic              w_is_io;
    io_sel_e           w_sel;
    logic              w_ram_we;
    logic [7:0]        w_mem_rd;
    logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]        w_tx_head, w_rx_head;
    logic [FIFO_LOG:0] w_tx_count, w_rx_count;
    logic              w_unused;

    assign w_idx    = bus.ram_addr[RAM_AW-1:0];
    assign w_is_io  = bus.ram_addr[IO_BIT];
    assign w_sel    = w_is_io ? io_decode(bus.ram_addr[2:0]) : IO_SEL_NONE;
    assign w_ram_we = rdy_i && !w_is_io && !bus.ram_rw;
    assign w_mem_rd = mem_q[w_idx];

    // Every FIFO handshake is qualified by rdy so a stalled bus freezes both queues.
    assign w_tx_push = rdy_i && (w_sel == IO_SEL_DATA) && !bus.ram_rw;
    assign w_rx_pop  = rdy_i && (w_sel == IO_SEL_DATA) &&  bus.ram_rw;
    assign w_tx_pop  = rdy_i && tx_valid_o && tx_ready_i;
    assign w_rx_push = rdy_i && rx_valid_i && rx_ready_o;

    byte_fifo #(.W(8), .LOG(FIFO_LOG)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_tx_push),
        .pop_i   (w_tx_pop),
        .din_i   (bus.ram_wdata),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty),
        .count_o (w_tx_count),
        .head_o  (w_tx_head)
    );

    byte_fifo #(.W(8), .LOG(FIFO_LOG)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_rx_push),
        .pop_i   (w_rx_pop),
        .din_i   (rx_data_i),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty),
        .count_o (w_rx_count),
        .head_o  (w_rx_head)
    );

    always_comb begin
        rdata_d    = rdata_q;
        overflow_d = overflow_q;
        halt_d     = halt_q;
        if (bus.ram_rw) begin
            if (!w_is_io) begin
                rdata_d = w_mem_rd;
            end else begin
                case (w_sel)
                    IO_SEL_DATA: rdata_d = w_rx_empty ? 8'h00 : w_rx_head;
                    IO_SEL_CTRL: rdata_d = {6'b0, !w_rx_empty, w_tx_full};
                    default:     rdata_d = 8'h00;
                endcase
            end
        end else begin
            // A push into a full TX queue is only lost if nothing drains this cycle.
            if (w_tx_push && w_tx_full && !w_tx_pop) overflow_d = 1'b1;
            if (w_sel == IO_SEL_CTRL)                halt_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= 8'h00;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else if (rdy_i) begin
            rdata_q    <= rdata_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) mem_q[w_idx] <= bus.ram_wdata;
    end

    assign bus.ram_rdata  = rdata_q;
    assign io_tx_full_o   = w_tx_full;
    assign tx_valid_o     = !w_tx_empty;
    assign tx_data_o      = w_tx_head;
    assign rx_ready_o     = !w_rx_full;
    assign tx_overflow_o  = overflow_q;
    assign sim_halt_o     = halt_q;

    assign w_unused = ^{bus.ram_addr[31:IO_BIT+1], w_tx_count, w_rx_count};

endmodule
`default_nettype wire
